gayle_bus_master: RTL



---
 rtl/gayle_pkg.sv | 33 +++
 rtl/gayle_bus_cycle.sv | 114 +++++++++++
 rtl/gayle_bus_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/gayle_pkg.sv
// Shared constants and state types for the Gayle register-block bus master.
// Included by gayle_bus_cycle and gayle_bus_master.
package gayle_pkg;

    localparam logic [23:0] AddrId     = 24'hDE1000;
    localparam logic [23:0] AddrIntchg = 24'hDA9000;
    localparam logic [23:0] AddrIntena = 24'hDAA000;

    localparam logic [3:0]  DefaultId  = 4'hD;

    localparam int unsigned CntW       = 8;

    typedef enum logic [2:0] {
        CycIdle,
        CycAddr,
        CycData,
        CycTerm,
        CycRecover
    } cyc_state_e;

    typedef enum logic [1:0] {
        JobNone,
        JobProbe,
        JobIntena,
        JobIntsvc
    } job_e;

    // Counters run from n-1 down to 0, so the load value is one less than the hold length.
    function automatic logic [CntW-1:0] cnt_load(input int unsigned n);
        return (n == 0) ? '0 : CntW'(n - 1);
    endfunction

endpackage

// File: rtl/gayle_bus_cycle.sv
// Single 68030-style AS20/DS20 bus cycle with fixed wait and recovery counts.
// A start request in the last recovery clock chains the next cycle back to back.
module gayle_bus_cycle
    import gayle_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned RECOVER_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_rw,
    input  logic [23:0] i_addr,
    input  logic        i_wdata,
    input  logic        i_d7,
    output logic        o_idle,
    output logic        o_done,
    output logic        o_rdata,
    output logic        o_as_n,
    output logic        o_ds_n,
    output logic        o_rw,
    output logic [23:0] o_addr,
    output logic        o_wdata
);

    cyc_state_e       r_state;
    cyc_state_e       w_state_d;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_d;
    logic             r_rw;
    logic [23:0]      r_addr;
    logic             r_wdata;
    logic             r_rdata;
    logic             w_latch;
    logic             w_sample;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_latch   = 1'b0;
        w_sample  = 1'b0;
        o_done    = 1'b0;
        unique case (r_state)
            CycIdle: begin
                if (i_start) begin
                    w_latch   = 1'b1;
                    w_state_d = CycAddr;
                end
            end
            CycAddr: begin
                w_state_d = CycData;
                w_cnt_d   = cnt_load(WAIT_CYCLES);
            end
            CycData: begin
                if (r_cnt == '0) begin
                    w_sample  = r_rw;
                    w_state_d = CycTerm;
                end else begin
                    w_cnt_d = r_cnt - CntW'(1);
                end
            end
            CycTerm: begin
                w_state_d = CycRecover;
                w_cnt_d   = cnt_load(RECOVER_CYCLES);
            end
            CycRecover: begin
                if (r_cnt == '0) begin
                    o_done = 1'b1;
                    if (i_start) begin
                        w_latch   = 1'b1;
                        w_state_d = CycAddr;
                    end else begin
                        w_state_d = CycIdle;
                    end
                end else begin
                    w_cnt_d = r_cnt - CntW'(1);
                end
            end
            default: w_state_d = CycIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CycIdle;
            r_cnt   <= '0;
            r_rw    <= 1'b1;
            r_addr  <= '0;
            r_wdata <= 1'b0;
            r_rdata <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_latch) begin
                r_rw    <= i_rw;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            if (w_sample) begin
                r_rdata <= i_d7;
            end
        end
    end

    // Strobes decode straight from state so the async reset releases them at once.
    assign o_idle  = (r_state == CycIdle);
    assign o_as_n  = !((r_state == CycAddr) || (r_state == CycData));
    assign o_ds_n  = !(r_state == CycData);
    assign o_rw    = r_rw;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/gayle_bus_master.sv
// Job sequencer (ID probe, INTENA write, optional INT2 service) over gayle_bus_cycle.
// Define GAYLE_INT_ACK_EN to build the INT2 synchroniser and automatic INTCHG service.
module gayle_bus_master
    import gayle_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned RECOVER_CYCLES = 1,
    parameter logic [3:0]  EXPECT_ID      = DefaultId
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        probe_req,
    input  logic        intena_req,
    input  logic        intena_val,
    input  logic        INT2,
    input  logic        D7_IN,
    output logic        busy,
    output logic [3:0]  id,
    output logic        id_valid,
    output logic        id_match,
    output logic        int_serviced,
    output logic        AS20,
    output logic        DS20,
    output logic        RW,
    output logic [23:0] A,
    output logic        D7_OUT
);

    job_e        r_job;
    job_e        w_job_d;
    logic [2:0]  r_step;
    logic [2:0]  w_step_d;
    logic        r_pend_probe;
    logic        r_pend_intena;
    logic        r_intena_val;
    logic [3:0]  r_id;
    logic [3:0]  w_id_d;
    logic        r_id_valid;
    logic        w_id_valid_d;
    logic        w_take_probe;
    logic        w_take_intena;
    logic        w_start;
    logic        w_rw;
    logic [23:0] w_addr;
    logic        w_wdata;
    logic        w_cyc_idle;
    logic        w_done;
    logic        w_rdata;

`ifdef GAYLE_INT_ACK_EN
    logic        r_int2_meta;
    logic        r_int2_sync;
    logic        r_pend_intsvc;
    logic        r_int_serviced;
    logic        w_take_intsvc;
    logic        w_svc_pulse;
`else
    logic        w_unused_int2;
    assign w_unused_int2 = INT2;
`endif

    gayle_bus_cycle #(
        .WAIT_CYCLES    (WAIT_CYCLES),
        .RECOVER_CYCLES (RECOVER_CYCLES)
    ) u_cycle (
        .i_clk   (CLKCPU),
        .i_rst_n (RESET),
        .i_start (w_start),
        .i_rw    (w_rw),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .i_d7    (D7_IN),
        .o_idle  (w_cyc_idle),
        .o_done  (w_done),
        .o_rdata (w_rdata),
        .o_as_n  (AS20),
        .o_ds_n  (DS20),
        .o_rw    (RW),
        .o_addr  (A),
        .o_wdata (D7_OUT)
    );

    always_comb begin
        w_job_d       = r_job;
        w_step_d      = r_step;
        w_id_d        = r_id;
        w_id_valid_d  = r_id_valid;
        w_take_probe  = 1'b0;
        w_take_intena = 1'b0;
        w_start       = 1'b0;
        w_rw          = 1'b1;
        w_addr        = AddrId;
        w_wdata       = 1'b0;
`ifdef GAYLE_INT_ACK_EN
        w_take_intsvc = 1'b0;
        w_svc_pulse   = 1'b0;
`endif
        if (r_job == JobNone) begin
            if (w_cyc_idle) begin
`ifdef GAYLE_INT_ACK_EN
                if (r_pend_intsvc) begin
                    w_take_intsvc = 1'b1;
                    w_job_d       = JobIntsvc;
                    w_step_d      = 3'd0;
                    w_start       = 1'b1;
                    w_rw          = 1'b1;
                    w_addr        = AddrIntchg;
                end else
`endif
                if (r_pend_probe) begin
                    w_take_probe = 1'b1;
                    w_job_d      = JobProbe;
                    w_step_d     = 3'd0;
                    w_id_valid_d = 1'b0;
                    w_start      = 1'b1;
                    w_rw         = 1'b0;
                    w_addr       = AddrId;
                    w_wdata      = 1'b1;
                end else if (r_pend_intena) begin
                    w_take_intena = 1'b1;
                    w_job_d       = JobIntena;
                    w_step_d      = 3'd0;
                    w_start       = 1'b1;
                    w_rw          = 1'b0;
                    w_addr        = AddrIntena;
                    w_wdata       = r_intena_val;
                end
            end
        end else if (w_done) begin
            unique case (r_job)
                JobProbe: begin
                    // Step 0 is the shifter-reset write; steps 1..4 are the ID reads.
                    if (r_step != 3'd0) begin
                        w_id_d = {r_id[2:0], w_rdata};
                    end
                    if (r_step == 3'd4) begin
                        w_job_d      = JobNone;
                        w_id_valid_d = 1'b1;
                    end else begin
                        w_start  = 1'b1;
                        w_rw     = 1'b1;
                        w_addr   = AddrId;
                        w_step_d = r_step + 3'd1;
                    end
                end
                JobIntena: w_job_d = JobNone;
`ifdef GAYLE_INT_ACK_EN
                JobIntsvc: begin
                    if ((r_step == 3'd0) && w_rdata) begin
                        w_start  = 1'b1;
                        w_rw     = 1'b0;
                        w_addr   = AddrIntchg;
                        w_wdata  = 1'b0;
                        w_step_d = 3'd1;
                    end else begin
                        w_job_d     = JobNone;
                        w_svc_pulse = (r_step != 3'd0);
                    end
                end
`endif
                default: w_job_d = JobNone;
            endcase
        end
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            r_job         <= JobNone;
            r_step        <= 3'd0;
            r_pend_probe  <= 1'b0;
            r_pend_intena <= 1'b0;
            r_intena_val  <= 1'b0;
            r_id          <= 4'h0;
            r_id_valid    <= 1'b0;
        end else begin
            r_job         <= w_job_d;
            r_step        <= w_step_d;
            r_id          <= w_id_d;
            r_id_valid    <= w_id_valid_d;
            // A fresh pulse on the acceptance clock stays pending as a new request.
            r_pend_probe  <= (r_pend_probe & ~w_take_probe) | probe_req;
            r_pend_intena <= (r_pend_intena & ~w_take_intena) | intena_req;
            if (intena_req) begin
                r_intena_val <= intena_val;
            end
        end
    end

`ifdef GAYLE_INT_ACK_EN
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            r_int2_meta    <= 1'b1;
            r_int2_sync    <= 1'b1;
            r_pend_intsvc  <= 1'b0;
            r_int_serviced <= 1'b0;
        end else begin
            r_int2_meta    <= INT2;
            r_int2_sync    <= r_int2_meta;
            r_int_serviced <= w_svc_pulse;
            // INT2 is ignored while a service job runs; it is looked at again once it ends.
            r_pend_intsvc  <= (r_pend_intsvc & ~w_take_intsvc)
                            | (~r_int2_sync & (r_job != JobIntsvc) & ~w_take_intsvc);
        end
    end

    assign int_serviced = r_int_serviced;
`else
    assign int_serviced = 1'b0;
`endif

    assign busy     = (r_job != JobNone);
    assign id       = r_id;
    assign id_valid = r_id_valid;
    assign id_match = r_id_valid && (r_id == EXPECT_ID);

endmodule
